scheduled_delay_buffer: RTL

- Write-side counterpart of the variable delay line: random-access (scheduled) write, FIFO-order read.
- Each accepted input sample is placed into a circular buffer slot `delay` ticks ahead of the read pointer.
- The buffer is read out sequentially, one slot per tick. Empty slots emit DEFAULT_DATA.
- Used in DSP/timing paths to play samples out at a per-sample scheduled time, e.g. jitter/reorder buffers and per-sample advance in filter chains.

---
 rtl/scheduled_delay_buffer_if.sv | 37 +++
 rtl/scheduled_delay_buffer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/scheduled_delay_buffer_if.sv
// Sample bus for scheduled_delay_buffer: scheduled write side and FIFO-order read side.
// Optional occupancy output when SCHEDULED_DELAY_BUFFER_OCCUPANCY_EN is defined.
interface scheduled_delay_buffer_if #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int OCC_W  = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]  data_in;
    logic              stb_in;
    logic [ADDR_W-1:0] delay;
    logic [WIDTH-1:0]  data_out;
    logic              stb_out;
    logic              collision;
`ifdef SCHEDULED_DELAY_BUFFER_OCCUPANCY_EN
    logic [OCC_W-1:0]  occupancy;

    modport master (
        output data_in, stb_in, delay,
        input  data_out, stb_out, collision, occupancy
    );
    modport slave (
        input  data_in, stb_in, delay,
        output data_out, stb_out, collision, occupancy
    );
`else
    modport master (
        output data_in, stb_in, delay,
        input  data_out, stb_out, collision
    );
    modport slave (
        input  data_in, stb_in, delay,
        output data_out, stb_out, collision
    );
`endif
endinterface

// File: rtl/scheduled_delay_buffer.sv
// Scheduled-write, sequential-read circular delay buffer (write-side delay line).
// Define SCHEDULED_DELAY_BUFFER_OCCUPANCY_EN to add the registered occupancy count.
module scheduled_delay_buffer #(
    parameter int               WIDTH        = 18,
    parameter int               DEPTH        = 16,
    parameter logic [WIDTH-1:0] DEFAULT_DATA = '0,
    parameter int               OUT_REG      = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_en,
    scheduled_delay_buffer_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] rd_ptr;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  valid_nxt;

    logic              tick;
    logic              bypass;
    logic [ADDR_W-1:0] slot;
    logic              rd_hit;
    logic [WIDTH-1:0]  out_val;
    logic              coll;

    logic [WIDTH-1:0]  data_q;
    logic              stb_q;
    logic              coll_q;

    assign tick   = clk_en & bus.stb_in;
    assign bypass = (bus.delay == '0);
    assign slot   = rd_ptr + bus.delay;
    assign rd_hit = valid[rd_ptr];

    always_comb begin
        out_val = DEFAULT_DATA;
        coll    = 1'b0;
        if (bypass) begin
            out_val = bus.data_in;
            coll    = rd_hit;
        end else begin
            if (rd_hit)
                out_val = mem[rd_ptr];
            coll = valid[slot];
        end
    end

    // Read slot is always freed; a non-zero delay never targets it.
    always_comb begin
        valid_nxt         = valid;
        valid_nxt[rd_ptr] = 1'b0;
        if (!bypass)
            valid_nxt[slot] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (tick && !bypass)
            mem[slot] <= bus.data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            valid  <= '0;
            data_q <= DEFAULT_DATA;
            stb_q  <= 1'b0;
            coll_q <= 1'b0;
        end else if (tick) begin
            rd_ptr <= rd_ptr + 1'b1;
            valid  <= valid_nxt;
            data_q <= out_val;
            stb_q  <= 1'b1;
            coll_q <= coll;
        end else begin
            stb_q  <= 1'b0;
            coll_q <= 1'b0;
        end
    end

    // Extra stage runs every clk so latency stays fixed regardless of clk_en.
    if (OUT_REG != 0) begin : g_out_reg
        logic [WIDTH-1:0] data_r;
        logic             stb_r;
        logic             coll_r;

        always_ff @(posedge clk) begin
            if (reset) begin
                data_r <= DEFAULT_DATA;
                stb_r  <= 1'b0;
                coll_r <= 1'b0;
            end else begin
                data_r <= data_q;
                stb_r  <= stb_q;
                coll_r <= coll_q;
            end
        end

        assign bus.data_out  = data_r;
        assign bus.stb_out   = stb_r;
        assign bus.collision = coll_r;
    end else begin : g_out_comb
        assign bus.data_out  = data_q;
        assign bus.stb_out   = stb_q;
        assign bus.collision = coll_q;
    end

`ifdef SCHEDULED_DELAY_BUFFER_OCCUPANCY_EN
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [OCC_W-1:0] occ;
    logic             occ_inc;
    logic             occ_dec;

    assign occ_inc = !bypass && !valid[slot];
    assign occ_dec = rd_hit;

    always_ff @(posedge clk) begin
        if (reset)
            occ <= '0;
        else if (tick)
            occ <= occ + OCC_W'(occ_inc) - OCC_W'(occ_dec);
    end

    assign bus.occupancy = occ;
`endif
endmodule
